io_hub: RTL and testbench
=========================

# io_hub

Parametrised memory-mapped I/O controller for the single-cycle MIPS core, replacing the fixed switch/LED/button glue with a register-mapped block that the core reaches through the existing IORead/IOWrite decode (ALU_result[31:10] all ones). It provides synchronised switch reads, a writable LED register, debounced buttons with sticky press flags, and a programmable down-counting timer. A single interrupt-style status line summarises pending events for polling firmware.

## Interface
- SW_WIDTH, 24, switch inputs sampled; 1..32
- LED_WIDTH, 24, LED outputs driven; 1..32
- BTN_COUNT, 5, button inputs debounced; 1..32
- DEBOUNCE_CYCLES, 230000, consecutive stable cycles required to accept a button level change; ≥2
- clock  in  1  system clock (CPU clock domain)
- rst_n  in  1  asynchronous active-low reset
- io_read  in  1  CPU read strobe for this block
- io_write  in  1  CPU write strobe for this block
- addr  in  10  byte offset (ALU_result[9:0]); bits [1:0] ignored
- wdata  in  32  write data (Read_data_2)
- rdata  out  32  read data to MemorIO mux
- switch  in  SW_WIDTH  raw asynchronous switches
- button  in  BTN_COUNT  raw asynchronous buttons, active-high
- led  out  LED_WIDTH  LED register
- irq  out  1  OR of all BTN_PEND bits and TIMER EXPIRED

## Operation
- Register map (word offsets):
  - 0x00 SW (RO): two-flop synchronised switches, zero-extended.
  - 0x04 LED (RW): write loads wdata[LED_WIDTH-1:0]; read returns it zero-extended.
  - 0x08 BTN_LEVEL (RO): debounced levels.
  - 0x0C BTN_PEND (RW1C): bit set on debounced 0→1 edge; writing 1 clears, 0 no effect.
  - 0x10 TIMER_LOAD (RW): write sets reload and count to wdata; read returns current count.
  - 0x14 TIMER_CTRL (RW): bit0 EN, bit1 AUTO, bit2 EXPIRED (W1C; write bit2=0 leaves it). Bits [31:3] read 0.
- Unmapped offsets: read 0, write ignored. rdata = 0 whenever io_read = 0.
- Debounce, per button: two-flop sync; counter clears when sync == level; increments when sync != level; when counter == DEBOUNCE_CYCLES-1 and sync != level: level <= sync, counter <= 0, and if new level is 1, pending <= 1.
- Timer: when EN and count > 1, count decrements. When EN and count == 1: EXPIRED <= 1, count <= AUTO ? reload : 0. When count == 0, hold, no further expiry. EN = 0 freezes count.
- Reset: led, sync flops, levels, counters, pending, count, reload, ctrl all 0; rdata 0; irq 0.

## Timing
- Reads combinational from addr same cycle (single-cycle core); writes take effect at the clock edge with io_write high.
- Switch change visible in SW read 2 cycles after it settles at the input.
- Button press visible in BTN_LEVEL and BTN_PEND 2 + DEBOUNCE_CYCLES cycles after a clean input edge; bounce shorter than DEBOUNCE_CYCLES never changes level.
- Simultaneous set and W1C of the same pending bit or EXPIRED in one cycle: set wins, bit stays 1.
- Write to TIMER_LOAD same cycle as an expiry tick: the write wins for count; EXPIRED still sets.
- Write to TIMER_CTRL with EN=1 loads control; decrement starts the following edge.
- irq is registered-state derived (combinational OR of flops), glitch-free, updates the cycle after the causing edge.
- rst_n assertion mid-debounce or mid-count clears everything immediately; no pending event survives.

## Test plan
- Reset: hold rst_n low with switches = 0xA5A5A5, buttons high -> led = 0, rdata = 0, irq = 0; after release, SW read = 0x00A5A5A5 at cycle 2.
- LED: write 0xFFFF1234 to 0x04 with LED_WIDTH=24 -> led = 0xFF1234, read 0x04 = 0x00FF1234; write to 0x3C ignored, read 0.
- Debounce (DEBOUNCE_CYCLES=8): button[2] toggles every 3 cycles then holds 1 -> BTN_LEVEL bit2 rises exactly 10 cycles after final edge, BTN_PEND = 0x4, irq = 1; write 0x4 to 0x0C -> BTN_PEND = 0, irq = 0.
- W1C race: clear BTN_PEND bit0 on the same edge a new press is accepted -> bit0 remains 1.
- Timer one-shot: LOAD = 3, CTRL = 0x1 -> count 3,2,1,0, EXPIRED set on 3rd edge, count holds 0; auto mode CTRL = 0x3 -> count reloads 3, EXPIRED every 3 cycles.
- Reset mid-count: assert rst_n with count = 2 -> count, ctrl, irq = 0 immediately, no expiry after release.

Source files
------------

// File: rtl/io_hub_if.sv
// ---------------------------------------------------------------------------
// io_hub_if
//   CPU-side register bus of the I/O hub: strobes, byte address, write data
//   and the combinational read data returned to the MemorIO mux.
//
//   master : CPU / address decoder (drives strobes, addr, wdata)
//   slave  : io_hub (returns rdata)
// ---------------------------------------------------------------------------
interface io_hub_if;
  logic        io_read;   // read strobe for this block
  logic        io_write;  // write strobe for this block
  logic [9:0]  addr;      // byte offset, bits [1:0] ignored
  logic [31:0] wdata;     // write data
  logic [31:0] rdata;     // read data, zero when io_read is low

  modport master (output io_read, io_write, addr, wdata, input rdata);
  modport slave  (input io_read, io_write, addr, wdata, output rdata);
endinterface

// File: rtl/io_hub.sv
// ---------------------------------------------------------------------------
// io_hub
//   Memory-mapped I/O block for the single-cycle MIPS core: synchronised
//   switches, a writable LED register, debounced buttons with sticky press
//   flags, and a programmable down-counting timer. irq summarises pending
//   button presses and timer expiry for polling firmware.
//
//   Ports
//     clock   : system clock (CPU domain)
//     rst_n   : asynchronous active-low reset
//     bus     : register bus (io_hub_if.slave)
//     switch  : raw asynchronous switches
//     button  : raw asynchronous active-high buttons
//     led     : LED register
//     irq     : OR of all pending button flags and timer EXPIRED
//
//   Word map: 0 SW, 1 LED, 2 BTN_LEVEL, 3 BTN_PEND (W1C), 4 TIMER_LOAD,
//             5 TIMER_CTRL {EXPIRED(W1C), AUTO, EN}. Others read 0.
// ---------------------------------------------------------------------------
module io_hub #(
  parameter int SW_WIDTH        = 24,
  parameter int LED_WIDTH       = 24,
  parameter int BTN_COUNT       = 5,
  parameter int DEBOUNCE_CYCLES = 230000
) (
  input  logic                 clock,
  input  logic                 rst_n,
  io_hub_if.slave              bus,
  input  logic [SW_WIDTH-1:0]  switch,
  input  logic [BTN_COUNT-1:0] button,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [7:0] {
    REG_SW    = 8'h00,
    REG_LED   = 8'h01,
    REG_LEVEL = 8'h02,
    REG_PEND  = 8'h03,
    REG_LOAD  = 8'h04,
    REG_CTRL  = 8'h05
  } reg_e;

  typedef struct packed {
    logic expired;
    logic auto_reload;
    logic en;
  } ctrl_t;

  // State
  logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [BTN_COUNT-1:0] btn_meta_q, btn_sync_q;
  logic [BTN_COUNT-1:0] btn_level_q, btn_level_d;
  logic [BTN_COUNT-1:0] btn_pend_q, btn_pend_d;
  logic [CNT_W-1:0]     btn_cnt_q [BTN_COUNT];
  logic [CNT_W-1:0]     btn_cnt_d [BTN_COUNT];
  logic [31:0]          count_q, count_d;
  logic [31:0]          reload_q, reload_d;
  ctrl_t                ctrl_q, ctrl_d;

  // Decode
  reg_e                 word;
  logic                 wr_led, wr_pend, wr_load, wr_ctrl;
  logic [BTN_COUNT-1:0] btn_rise, btn_clr;
  logic                 expire;
  logic                 unused_addr;

  assign word        = reg_e'(bus.addr[9:2]);
  assign unused_addr = ^bus.addr[1:0];
  assign wr_led      = bus.io_write && (word == REG_LED);
  assign wr_pend     = bus.io_write && (word == REG_PEND);
  assign wr_load     = bus.io_write && (word == REG_LOAD);
  assign wr_ctrl     = bus.io_write && (word == REG_CTRL);
  assign btn_clr     = wr_pend ? bus.wdata[BTN_COUNT-1:0] : '0;

  // Next-state logic
  // NOTE: every variable written below gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    led_d       = led_q;
    btn_level_d = btn_level_q;
    btn_cnt_d   = btn_cnt_q;
    btn_rise    = '0;
    count_d     = count_q;
    reload_d    = reload_q;
    ctrl_d      = ctrl_q;
    expire      = 1'b0;

    if (wr_led) led_d = bus.wdata[LED_WIDTH-1:0];

    // Debounce: a level change is accepted only after the synchronised
    // input has disagreed with the level for DEBOUNCE_CYCLES edges in a row.
    for (int i = 0; i < BTN_COUNT; i++) begin
      if (btn_sync_q[i] == btn_level_q[i]) begin
        btn_cnt_d[i] = '0;
      end else if (btn_cnt_q[i] == CNT_MAX) begin
        btn_level_d[i] = btn_sync_q[i];
        btn_cnt_d[i]   = '0;
        btn_rise[i]    = btn_sync_q[i];
      end else begin
        btn_cnt_d[i] = btn_cnt_q[i] + CNT_ONE;
      end
    end

    // A new press outranks a simultaneous clear of the same bit.
    btn_pend_d = (btn_pend_q & ~btn_clr) | btn_rise;

    // Timer: count == 1 is the expiry tick; count == 0 is a dead stop.
    if (ctrl_q.en) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        expire  = 1'b1;
        count_d = ctrl_q.auto_reload ? reload_q : '0;
      end
    end

    // A LOAD write overrides whatever the tick chose for count.
    if (wr_load) begin
      reload_d = bus.wdata;
      count_d  = bus.wdata;
    end

    if (wr_ctrl) begin
      ctrl_d.en          = bus.wdata[0];
      ctrl_d.auto_reload = bus.wdata[1];
    end
    ctrl_d.expired = (ctrl_q.expired & ~(wr_ctrl & bus.wdata[2])) | expire;
  end

  // State registers
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the debounce counter array is reset too, so an interrupted
  // debounce cannot resume after rst_n is released.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      led_q       <= '0;
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
      btn_level_q <= '0;
      btn_pend_q  <= '0;
      for (int i = 0; i < BTN_COUNT; i++) btn_cnt_q[i] <= '0;
      count_q     <= '0;
      reload_q    <= '0;
      ctrl_q      <= '0;
    end else begin
      sw_meta_q   <= switch;
      sw_sync_q   <= sw_meta_q;
      led_q       <= led_d;
      btn_meta_q  <= button;
      btn_sync_q  <= btn_meta_q;
      btn_level_q <= btn_level_d;
      btn_pend_q  <= btn_pend_d;
      btn_cnt_q   <= btn_cnt_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      ctrl_q      <= ctrl_d;
    end
  end

  // Combinational read path for the single-cycle core.
  always_comb begin
    bus.rdata = '0;
    if (bus.io_read) begin
      case (word)
        REG_SW:    bus.rdata = 32'(sw_sync_q);
        REG_LED:   bus.rdata = 32'(led_q);
        REG_LEVEL: bus.rdata = 32'(btn_level_q);
        REG_PEND:  bus.rdata = 32'(btn_pend_q);
        REG_LOAD:  bus.rdata = count_q;
        REG_CTRL:  bus.rdata = {29'd0, ctrl_q};
        default:   bus.rdata = '0;
      endcase
    end
  end

  assign led = led_q;
  assign irq = (|btn_pend_q) | ctrl_q.expired;

endmodule

// File: tb/tb_io_hub.sv
// ---------------------------------------------------------------------------
// tb_io_hub
//   Self-checking bench for io_hub with a short debounce window. Expected
//   values come from the register-map rules: latencies as cycle arithmetic,
//   timer counts as closed-form functions of elapsed edges.
// ---------------------------------------------------------------------------
module tb_io_hub;

  localparam int SW_W  = 24;
  localparam int LED_W = 24;
  localparam int BTN_N = 5;
  localparam int DEB   = 8;

  localparam logic [9:0] A_SW    = 10'h000;
  localparam logic [9:0] A_LED   = 10'h004;
  localparam logic [9:0] A_LVL   = 10'h008;
  localparam logic [9:0] A_PEND  = 10'h00C;
  localparam logic [9:0] A_LOAD  = 10'h010;
  localparam logic [9:0] A_CTRL  = 10'h014;
  localparam logic [9:0] A_UNMAP = 10'h03C;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic [SW_W-1:0]  switch;
  logic [BTN_N-1:0] button;
  logic [LED_W-1:0] led;
  logic             irq;

  int vectors    = 0;
  int miscompares = 0;

  io_hub_if bus ();

  io_hub #(
    .SW_WIDTH       (SW_W),
    .LED_WIDTH      (LED_W),
    .BTN_COUNT      (BTN_N),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus),
    .switch(switch),
    .button(button),
    .led   (led),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
    bus.io_write = 1'b1;
    bus.addr     = a;
    bus.wdata    = d;
    @(posedge clock);
    #1;
    bus.io_write = 1'b0;
    bus.wdata    = '0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
    bus.io_read = 1'b1;
    bus.addr    = a;
    #1;
    d = bus.rdata;
    bus.io_read = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] got;
    rst_n        = 1'b0;
    switch       = 24'hA5A5A5;
    button       = '1;
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    bus.addr     = A_SW;
    bus.wdata    = '0;
    repeat (3) tick();
    vectors++; if (led !== '0) begin miscompares++; $display("FAIL reset_led got=%h exp=%h", led, 24'h0); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b exp=0", irq); end
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata_idle got=%h exp=0", bus.rdata); end
    bus_read(A_SW, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL reset_sw_read got=%h exp=0", got); end
    bus_read(A_LVL, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL reset_level got=%h exp=0", got); end
    button = '0;
    rst_n  = 1'b1;
    tick();
    bus_read(A_SW, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL sw_cycle1 got=%h exp=0", got); end
    tick();
    bus_read(A_SW, got);
    vectors++; if (got !== 32'h00A5A5A5) begin miscompares++; $display("FAIL sw_cycle2 got=%h exp=%h", got, 32'h00A5A5A5); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_led_sw();
    logic [31:0] got, d, exp_led;
    logic [9:0]  a;
    logic [SW_W-1:0] sw_old, sw_new;
    bus_write(A_LED, 32'hFFFF1234);
    vectors++; if (led !== 24'hFF1234) begin miscompares++; $display("FAIL led_out got=%h exp=%h", led, 24'hFF1234); end
    bus_read(A_LED, got);
    vectors++; if (got !== 32'h00FF1234) begin miscompares++; $display("FAIL led_read got=%h exp=%h", got, 32'h00FF1234); end
    bus_write(A_UNMAP, 32'hDEADBEEF);
    bus_read(A_UNMAP, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got=%h exp=0", got); end
    vectors++; if (led !== 24'hFF1234) begin miscompares++; $display("FAIL unmapped_write_led got=%h exp=%h", led, 24'hFF1234); end
    bus.addr = A_LED;
    #1;
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rdata_no_read got=%h exp=0", bus.rdata); end

    exp_led = 32'h00FF1234;
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      bus_write(A_LED, d);
      exp_led = {8'h00, d[23:0]};
      bus_read(A_LED, got);
      vectors++; if (got !== exp_led) begin miscompares++; $display("FAIL led_rand_read got=%h exp=%h", got, exp_led); end
      a = 10'($urandom_range(6, 255)) << 2;
      bus_write(a, $urandom);
      bus_read(a, got);
      vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL unmapped_rand addr=%h got=%h exp=0", a, got); end
      vectors++; if (32'(led) !== exp_led) begin miscompares++; $display("FAIL led_rand_out got=%h exp=%h", led, exp_led); end

      sw_old = switch;
      sw_new = SW_W'($urandom);
      switch = sw_new;
      tick();
      bus_read(A_SW, got);
      vectors++; if (got !== 32'(sw_old)) begin miscompares++; $display("FAIL sw_lat1 got=%h exp=%h", got, 32'(sw_old)); end
      tick();
      bus_read(A_SW, got);
      vectors++; if (got !== 32'(sw_new)) begin miscompares++; $display("FAIL sw_lat2 got=%h exp=%h", got, 32'(sw_new)); end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_debounce();
    logic [31:0] got, exp;
    int idx, edges, hold;
    for (int trial = 0; trial < 3; trial++) begin
      idx   = (trial == 0) ? 2 : int'($urandom_range(0, BTN_N - 1));
      edges = (trial == 0) ? 5 : 2 * int'($urandom_range(1, 3)) + 1;
      // Bounce: every hold is shorter than the debounce window.
      for (int e = 0; e < edges; e++) begin
        hold = (trial == 0) ? 3 : int'($urandom_range(1, DEB - 1));
        button[idx] = ~button[idx];
        if (e == edges - 1) break;
        for (int c = 0; c < hold; c++) begin
          tick();
          bus_read(A_LVL, got);
          vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL bounce_level btn=%0d got=%h exp=0", idx, got); end
        end
      end
      // Final clean rising edge: accepted exactly 2 + DEB edges later.
      for (int n = 1; n <= 2 + DEB; n++) begin
        tick();
        bus_read(A_LVL, got);
        exp = (n == 2 + DEB) ? (32'd1 << idx) : 32'd0;
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL level_rise btn=%0d n=%0d got=%h exp=%h", idx, n, got, exp); end
      end
      bus_read(A_PEND, got);
      vectors++; if (got !== (32'd1 << idx)) begin miscompares++; $display("FAIL pend_set got=%h exp=%h", got, 32'd1 << idx); end
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_pend got=%b exp=1", irq); end
      bus_write(A_PEND, 32'd1 << idx);
      bus_read(A_PEND, got);
      vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL pend_clear got=%h exp=0", got); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got=%b exp=0", irq); end
      button[idx] = 1'b0;
      repeat (2 + DEB) tick();
      bus_read(A_LVL, got);
      vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL level_fall got=%h exp=0", got); end
      bus_read(A_PEND, got);
      vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL pend_on_release got=%h exp=0", got); end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_w1c_race();
    logic [31:0] got;
    bus_write(A_PEND, 32'h1F);
    button[0] = 1'b1;
    repeat (2 + DEB) tick();
    bus_read(A_PEND, got);
    vectors++; if (got !== 32'h1) begin miscompares++; $display("FAIL race_setup_pend got=%h exp=1", got); end
    button[0] = 1'b0;
    repeat (2 + DEB) tick();
    bus_read(A_LVL, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL race_setup_level got=%h exp=0", got); end
    // Second press; the W1C write lands on the acceptance edge.
    button[0] = 1'b1;
    repeat (DEB + 1) tick();
    bus_write(A_PEND, 32'h1);
    bus_read(A_LVL, got);
    vectors++; if (got !== 32'h1) begin miscompares++; $display("FAIL race_level got=%h exp=1", got); end
    bus_read(A_PEND, got);
    vectors++; if (got !== 32'h1) begin miscompares++; $display("FAIL race_set_wins got=%h exp=1", got); end
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL race_later_clear got=%h exp=0", got); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL race_irq got=%b exp=0", irq); end
    button[0] = 1'b0;
    repeat (2 + DEB) tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timer_oneshot();
    logic [31:0] got, exp;
    int l;
    for (int trial = 0; trial < 3; trial++) begin
      l = (trial == 0) ? 3 : int'($urandom_range(2, 12));
      bus_write(A_LOAD, 32'(l));
      bus_write(A_CTRL, 32'h1);
      bus_read(A_LOAD, got);
      vectors++; if (got !== 32'(l)) begin miscompares++; $display("FAIL oneshot_start got=%0d exp=%0d", got, l); end
      for (int n = 1; n <= l + 2; n++) begin
        tick();
        bus_read(A_LOAD, got);
        exp = (n < l) ? 32'(l - n) : 32'd0;
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL oneshot_count L=%0d n=%0d got=%0d exp=%0d", l, n, got, exp); end
        bus_read(A_CTRL, got);
        exp = (n >= l) ? 32'h5 : 32'h1;
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL oneshot_ctrl L=%0d n=%0d got=%h exp=%h", l, n, got, exp); end
      end
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL oneshot_irq got=%b exp=1", irq); end
      bus_write(A_CTRL, 32'h4);
      bus_read(A_CTRL, got);
      vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL oneshot_w1c got=%h exp=0", got); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_irq_clr got=%b exp=0", irq); end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timer_auto();
    logic [31:0] got, exp;
    int l;
    logic prev_set;
    for (int trial = 0; trial < 2; trial++) begin
      l = (trial == 0) ? 3 : int'($urandom_range(2, 6));
      bus_write(A_LOAD, 32'(l));
      bus_write(A_CTRL, 32'h3);
      prev_set = 1'b0;
      for (int n = 1; n <= 3 * l; n++) begin
        // Clear EXPIRED on the edge right after it was seen.
        if (prev_set) bus_write(A_CTRL, 32'h7);
        else          tick();
        bus_read(A_LOAD, got);
        exp = 32'(l - (n % l));
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL auto_count L=%0d n=%0d got=%0d exp=%0d", l, n, got, exp); end
        bus_read(A_CTRL, got);
        exp = ((n % l) == 0) ? 32'h7 : 32'h3;
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL auto_ctrl L=%0d n=%0d got=%h exp=%h", l, n, got, exp); end
        prev_set = ((n % l) == 0);
      end
      bus_write(A_CTRL, 32'h4);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timer_races();
    logic [31:0] got;
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'h1);
    tick();
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'd1) begin miscompares++; $display("FAIL load_race_setup got=%0d exp=1", got); end
    bus_write(A_LOAD, 32'd5);
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'd5) begin miscompares++; $display("FAIL load_race_count got=%0d exp=5", got); end
    bus_read(A_CTRL, got);
    vectors++; if (got !== 32'h5) begin miscompares++; $display("FAIL load_race_expired got=%h exp=5", got); end
    tick();
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'd4) begin miscompares++; $display("FAIL load_race_next got=%0d exp=4", got); end
    bus_write(A_CTRL, 32'h4);
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'd3) begin miscompares++; $display("FAIL disable_edge got=%0d exp=3", got); end
    repeat (3) tick();
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'd3) begin miscompares++; $display("FAIL en0_freeze got=%0d exp=3", got); end
    bus_read(A_CTRL, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL en0_ctrl got=%h exp=0", got); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_count();
    logic [31:0] got;
    bus_write(A_LED, 32'h00ABCDEF);
    button[1] = 1'b1;
    repeat (2 + DEB) tick();
    bus_write(A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'h3);
    repeat (3) tick();
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'd2) begin miscompares++; $display("FAIL midcount_setup got=%0d exp=2", got); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL midcount_irq_before got=%b exp=1", irq); end
    rst_n = 1'b0;
    #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL midreset_irq got=%b exp=0", irq); end
    vectors++; if (led !== '0) begin miscompares++; $display("FAIL midreset_led got=%h exp=0", led); end
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL midreset_count got=%h exp=0", got); end
    bus_read(A_CTRL, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL midreset_ctrl got=%h exp=0", got); end
    bus_read(A_PEND, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL midreset_pend got=%h exp=0", got); end
    button[1] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    bus_read(A_LOAD, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL postreset_count got=%h exp=0", got); end
    bus_read(A_CTRL, got);
    vectors++; if (got !== 32'h0) begin miscompares++; $display("FAIL postreset_ctrl got=%h exp=0", got); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL postreset_irq got=%b exp=0", irq); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_led_sw();
    test_debounce();
    test_w1c_race();
    test_timer_oneshot();
    test_timer_auto();
    test_timer_races();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
